mem_bus_arbiter: RTL and testbench

- Shares one single-port data memory between two requesters.
- Port 0 is the CPU data port (load/store address, write data, write enable). Port 1 is a secondary master (program loader, display/peripheral reader).
- Fair round-robin arbitration, one transaction in flight at a time, fixed memory read latency.
- Returns a registered read-data word and a one-cycle ack per transaction. Port 0 also gets a stall flag for the future multicycle CPU sequencer.

---
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_bus_arbiter: round-robin sharing of one single-port memory   |
// | between a CPU data port (m0) and a secondary master (m1).        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic [1:0]        gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_ISSUE = 2'd1;
  localparam logic [1:0] C_ST_WAIT  = 2'd2;
  localparam logic [1:0] C_ST_ACK   = 2'd3;

  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("mem_bus_arbiter: RD_LAT must be in 1..4");
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_gnt_q, last_gnt_d;  // 1 = port 1 owned the last transaction
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic w_any_req;
  logic w_win1;

  assign w_any_req = m0_req | m1_req;
  assign w_win1    = m1_req & (~m0_req | ~last_gnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_IDLE:  if (w_any_req) state_d = C_ST_ISSUE;
      C_ST_ISSUE: state_d = we_q ? C_ST_ACK : C_ST_WAIT;
      C_ST_WAIT:  if (cnt_q == '0) state_d = C_ST_ACK;
      C_ST_ACK:   state_d = C_ST_IDLE;
      default:    state_d = C_ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en = (state_q == C_ST_ISSUE);
    mem_we = (state_q == C_ST_ISSUE) & we_q;
    m0_ack = (state_q == C_ST_ACK) & gnt_q[0];
    m1_ack = (state_q == C_ST_ACK) & gnt_q[1];
  end

  always_comb begin
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      C_ST_IDLE: begin
        if (w_any_req) begin
          gnt_d   = w_win1 ? 2'b10 : 2'b01;
          we_d    = w_win1 ? m1_we : m0_we;
          addr_d  = w_win1 ? m1_addr : m0_addr;
          wdata_d = w_win1 ? m1_wdata : m0_wdata;
        end
      end
      C_ST_ISSUE: begin
        if (!we_q) cnt_d = C_CNT_LOAD;
      end
      C_ST_WAIT: begin
        // Counter at zero marks the cycle mem_rdata is valid
        if (cnt_q == '0) begin
          if (gnt_q[1]) m1_rdata_d = mem_rdata;
          else          m0_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      C_ST_ACK: begin
        last_gnt_d = gnt_q[1];
        gnt_d      = 2'b00;
      end
      default: begin
        gnt_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= 2'b00;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_stall  = m0_req & ~m0_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_bus_arbiter;

  localparam int RD_LAT = 3;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack, m0_stall;
  logic [1:0]  gnt;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .gnt(gnt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h20) return 32'h1234_5678;
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  // Memory environment: fixed RD_LAT pipeline, junk when no read was issued
  logic [31:0] env_mem   [256];
  logic        env_valid [256];
  logic [31:0] pipe      [RD_LAT];
  int          junk = 0;

  always @(posedge clk) begin
    junk <= junk + 1;
    if (mem_en && !mem_we)
      pipe[0] <= env_valid[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
    else
      pipe[0] <= 32'hBAD0_0000 | junk;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    if (mem_en && mem_we) begin
      env_mem[mem_addr[7:0]]   <= mem_wdata;
      env_valid[mem_addr[7:0]] <= 1'b1;
    end
  end
  assign mem_rdata = pipe[RD_LAT-1];

  // Scoreboard
  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] data;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_rd(input logic [7:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic push_txn(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    exp_t e;
    e.port = port;
    e.we   = we;
    if (we) begin
      ref_mem[int'(addr[7:0])] = wdata;
      e.data = 32'h0;
    end else begin
      e.data = ref_rd(addr[7:0]);
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && (m0_ack || m1_ack)) begin
      check_eq("dual_ack", {63'h0, m0_ack & m1_ack}, 64'h0);
      if (sb.size() == 0) begin
        check_eq("unexpected_ack", {62'h0, m1_ack, m0_ack}, 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_port", {62'h0, m1_ack, m0_ack}, e.port ? 64'h2 : 64'h1);
        if (!e.we) check_eq("sb_rdata", e.port ? m1_rdata : m0_rdata, e.data);
      end
    end
  end

  // Wait for the ack of a port; cycle 0 is the first negedge seen
  task automatic wait_ack(input logic port, input int exp_cyc, input string tag);
    int en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 1) check_eq({tag, "_gnt"}, gnt, port ? 64'h2 : 64'h1);
      en_cnt += mem_en ? 1 : 0;
      if (port ? m1_ack : m0_ack) begin
        check_eq({tag, "_cyc"}, i, exp_cyc);
        check_eq({tag, "_en_cnt"}, en_cnt, 1);
        return;
      end
    end
    check_eq({tag, "_timeout"}, port ? m1_ack : m0_ack, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    rst = 1'b1;
    m0_req = $urandom_range(0, 1); m0_we = $urandom_range(0, 1);
    m0_addr = $urandom; m0_wdata = $urandom;
    m1_req = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
    m1_addr = $urandom; m1_wdata = $urandom;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_ctrl", {58'h0, gnt, mem_en, mem_we, m0_ack, m1_ack}, 64'h0);
      check_eq("rst_addr", mem_addr, 64'h0);
      check_eq("rst_wdata", mem_wdata, 64'h0);
      check_eq("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    end

    // Both ports hold read requests: m0 first, then strict alternation
    tick();
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hC;
    push_txn(1'b0, 1'b0, m0_addr, 32'h0);
    push_txn(1'b1, 1'b0, m1_addr, 32'h0);
    push_txn(1'b0, 1'b0, m0_addr, 32'h0);
    push_txn(1'b1, 1'b0, m1_addr, 32'h0);
    wait_ack(1'b0, 2 + RD_LAT, "rr0");
    wait_ack(1'b1, 2 + RD_LAT, "rr1");
    wait_ack(1'b0, 2 + RD_LAT, "rr2");
    wait_ack(1'b1, 2 + RD_LAT, "rr3");
    tick();
    m0_req = 1'b0; m1_req = 1'b0;

    // m0 write with cycle-accurate memory strobe checks
    tick();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF;
    push_txn(1'b0, 1'b1, m0_addr, m0_wdata);
    @(negedge clk);
    check_eq("w_c0_stall_en", {62'h0, m0_stall, mem_en}, 64'h2);
    @(negedge clk);
    check_eq("w_c1_en_we_stall", {61'h0, mem_en, mem_we, m0_stall}, 64'h7);
    check_eq("w_c1_addr", mem_addr, 64'h10);
    check_eq("w_c1_wdata", mem_wdata, 64'hDEAD_BEEF);
    @(negedge clk);
    check_eq("w_c2_ack_stall_en", {61'h0, m0_ack, m0_stall, mem_en}, 64'h4);
    tick();
    m0_req = 1'b0;
    @(negedge clk);
    check_eq("w_c3_ack", {63'h0, m0_ack}, 64'h0);

    // m1 read of 0x20; m0_rdata must not move
    tick();
    saved = m0_rdata;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    push_txn(1'b1, 1'b0, m1_addr, 32'h0);
    wait_ack(1'b1, 2 + RD_LAT, "m1rd");
    check_eq("m1rd_data", m1_rdata, 64'h1234_5678);
    check_eq("m1rd_m0_hold", m0_rdata, saved);
    tick();
    m1_req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("m1rd_hold", m1_rdata, 64'h1234_5678);

    // Reset in the second WAIT cycle of an m0 read: abandoned, no ack
    tick();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h30;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    m0_req = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_idle", {61'h0, gnt, mem_en}, 64'h0);
    check_eq("abort_rdata", {m0_rdata, m1_rdata}, 64'h0);
    repeat (8) @(negedge clk);
    check_eq("abort_rdata_late", m0_rdata, 64'h0);

    // Write then back-to-back read of the same address
    tick();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h4; m0_wdata = 32'h0000_00AA;
    push_txn(1'b0, 1'b1, m0_addr, m0_wdata);
    push_txn(1'b0, 1'b0, m0_addr, 32'h0);
    wait_ack(1'b0, 2, "wr4");
    tick();
    m0_we = 1'b0;
    wait_ack(1'b0, 2 + RD_LAT, "rd4");
    check_eq("rd4_data", m0_rdata, 64'hAA);
    tick();
    m0_req = 1'b0;

    // Random single transactions
    for (int k = 0; k < 8; k++) begin
      logic        p, w;
      logic [31:0] a, d;
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      d = $urandom;
      tick();
      if (p) begin m1_req = 1'b1; m1_we = w; m1_addr = a; m1_wdata = d; end
      else   begin m0_req = 1'b1; m0_we = w; m0_addr = a; m0_wdata = d; end
      push_txn(p, w, a, d);
      wait_ack(p, w ? 2 : 2 + RD_LAT, "rnd");
      tick();
      m0_req = 1'b0; m1_req = 1'b0;
    end

    repeat (4) @(negedge clk);
    check_eq("sb_left", sb.size(), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
